// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one 32-bit combinational ALU between two requesters,
// with a registered response channel and saturating per-requester grant counters.

module alu_share_arbiter_alu (
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        zero
);
  always_comb begin
    result = '0;
    case (op)
      3'b000:  result = a & b;
      3'b001:  result = a | b;
      3'b010:  result = a + b;
      3'b011:  result = a - b;
      3'b100:  result = (b >= 32'd32) ? '0 : (a << b[4:0]);
      3'b101:  result = ~(a | b);
      default: result = '0;
    endcase
    zero = (result == '0);
  end
endmodule

module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic                  resp_id,
  output logic [DATA_WIDTH-1:0] resp_result,
  output logic                  resp_zero,
  output logic [CNT_WIDTH-1:0]  gnt_cnt0,
  output logic [CNT_WIDTH-1:0]  gnt_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state, state_nxt;
  logic                  ptr;
  logic                  grant0, grant1;
  logic [OP_WIDTH-1:0]   op_q;
  logic [DATA_WIDTH-1:0] a_q, b_q;
  logic                  id_q;
  logic [DATA_WIDTH-1:0] alu_result;
  logic                  alu_zero;

  // Arbitration decision is independent of state; the ready outputs gate it with IDLE.
  assign grant0 = req0_valid && (!req1_valid || !ptr);
  assign grant1 = req1_valid && (!req0_valid ||  ptr);

  alu_share_arbiter_alu u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (alu_result),
    .zero   (alu_zero)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant0 || grant1) state_nxt = EXEC;
      EXEC:    state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = (state == IDLE) && grant0;
    req1_ready = (state == IDLE) && grant1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= 1'b0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      gnt_cnt0    <= '0;
      gnt_cnt1    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant1) begin
            op_q <= req1_op;
            a_q  <= req1_a;
            b_q  <= req1_b;
            id_q <= 1'b1;
            ptr  <= 1'b0;
            if (gnt_cnt1 != '1) gnt_cnt1 <= gnt_cnt1 + 1'b1;
          end else if (grant0) begin
            op_q <= req0_op;
            a_q  <= req0_a;
            b_q  <= req0_b;
            id_q <= 1'b0;
            ptr  <= 1'b1;
            if (gnt_cnt0 != '1) gnt_cnt0 <= gnt_cnt0 + 1'b1;
          end
        end
        EXEC: begin
          resp_result <= alu_result;
          resp_zero   <= alu_zero;
          resp_id     <= id_q;
          resp_valid  <= 1'b1;
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: scoreboard of expected responses checked
// with immediate assertions, plus a narrow-counter instance for saturation.

module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic        resp_valid, resp_id, resp_zero;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_result;
  logic [15:0] gnt_cnt0, gnt_cnt1;

  logic        s_req0_valid = 1'b0;
  logic        s_req0_ready, s_req1_ready;
  logic        s_resp_valid, s_resp_id, s_resp_zero;
  logic [31:0] s_resp_result;
  logic [1:0]  s_gnt_cnt0, s_gnt_cnt1;

  int checks = 0;
  int failures = 0;
  logic [33:0] sb[$];   // {id, zero, result}

  always #5 clk = ~clk;

  alu_share_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_zero(resp_zero),
    .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
  );

  alu_share_arbiter #(.CNT_WIDTH(2)) dut_sat (
    .clk(clk), .reset(reset),
    .req0_valid(s_req0_valid), .req0_ready(s_req0_ready), .req0_op(3'b010),
    .req0_a(32'd1), .req0_b(32'd2),
    .req1_valid(1'b0), .req1_ready(s_req1_ready), .req1_op(3'b000),
    .req1_a(32'd0), .req1_b(32'd0),
    .resp_valid(s_resp_valid), .resp_ready(1'b1), .resp_id(s_resp_id),
    .resp_result(s_resp_result), .resp_zero(s_resp_zero),
    .gnt_cnt0(s_gnt_cnt0), .gnt_cnt1(s_gnt_cnt1)
  );

  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a + b;
      3'd3: return a - b;
      3'd4: return (b > 32'd31) ? 32'd0 : a << b;
      3'd5: return ~(a | b);
      default: return 32'd0;
    endcase
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    r = model(op, a, b);
    sb.push_back({id, (r == 32'd0), r});
  endtask

  // Drives one requester, waits (bounded) for its ready, scoreboards, takes the accepting edge.
  task automatic issue(input logic id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit push);
    if (id) begin req1_valid = 1'b1; req1_op = op; req1_a = a; req1_b = b; end
    else    begin req0_valid = 1'b1; req0_op = op; req0_a = a; req0_b = b; end
    #1;
    for (int c = 0; c < 20 && !(id ? req1_ready : req0_ready); c++) tick;
    check("accept_ready", id ? req1_ready : req0_ready, 1'b1);
    if (push) push_exp(id, op, a, b);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Waits for a response, holds it under backpressure for 'hold' cycles, then pops and compares.
  task automatic get_resp(input int hold);
    logic [33:0] e;
    for (int c = 0; c < 10 && !resp_valid; c++) tick;
    check("resp_valid_timeout", resp_valid, 1'b1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      tick;
      check("hold_valid", resp_valid, 1'b1);
      check("hold_result", {resp_id, resp_zero, resp_result}, e);
      check("hold_ready", {req0_ready, req1_ready}, 2'b00);
    end
    check("resp_id", resp_id, e[33]);
    check("resp_zero", resp_zero, e[32]);
    check("resp_result", resp_result, e[31:0]);
    resp_ready = 1'b1;
    #1;
    check("resp_cycle_ready", {req0_ready, req1_ready}, 2'b00);
    tick;
    resp_ready = 1'b0;
    check("resp_cleared", resp_valid, 1'b0);
  endtask

  initial begin
    logic saw_valid;
    int exp_sat [5] = '{1, 2, 3, 3, 3};

    tick; tick;
    reset = 1'b0;
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_bus", {resp_id, resp_zero, resp_result}, 34'd0);
    check("rst_cnts", {gnt_cnt0, gnt_cnt1}, 32'd0);

    // single request: ADD 5+7, response after two edges
    issue(1'b0, 3'b010, 32'd5, 32'd7, 1'b1);
    check("exec_no_valid", resp_valid, 1'b0);
    tick;
    check("latency_valid", resp_valid, 1'b1);
    get_resp(0);
    check("cnt0_after_one", gnt_cnt0, 16'd1);

    // zero flag via SUB and unused op code
    issue(1'b1, 3'b011, 32'h1234, 32'h1234, 1'b1);
    get_resp(0);
    issue(1'b1, 3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    get_resp(0);
    issue(1'b0, 3'b100, 32'd1, 32'd40, 1'b1);
    get_resp(0);

    // contention from a fresh reset: strict 0,1,0,1 alternation
    reset = 1'b1; tick; reset = 1'b0;
    req0_valid = 1'b1; req0_op = 3'b001; req0_a = 32'hF0; req0_b = 32'h0F;
    req1_valid = 1'b1; req1_op = 3'b100; req1_a = 32'd1;  req1_b = 32'd31;
    #1;
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < 20 && !(req0_ready || req1_ready); c++) tick;
      check("contention_grant", {req1_ready, req0_ready}, (i % 2) ? 2'b10 : 2'b01);
      if (req1_ready) push_exp(1'b1, req1_op, req1_a, req1_b);
      else            push_exp(1'b0, req0_op, req0_a, req0_b);
      tick;
      get_resp(0);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    check("contention_cnts", {gnt_cnt0, gnt_cnt1}, {16'd2, 16'd2});

    // backpressure with a pending request held by requester 0
    issue(1'b0, 3'b000, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b1);
    req0_valid = 1'b1; req0_op = 3'b101; req0_a = 32'd0; req0_b = 32'd0;
    get_resp(5);
    #1;
    check("accept_after_resp", req0_ready, 1'b1);
    push_exp(1'b0, 3'b101, 32'd0, 32'd0);
    tick;
    req0_valid = 1'b0;
    get_resp(0);

    // reset during EXEC discards the response
    issue(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b0);
    reset = 1'b1; tick; reset = 1'b0;
    check("midrst_valid", resp_valid, 1'b0);
    check("midrst_cnts", {gnt_cnt0, gnt_cnt1}, 32'd0);
    saw_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (resp_valid) saw_valid = 1'b1;
    end
    check("midrst_no_resp", saw_valid, 1'b0);
    issue(1'b0, 3'b010, 32'hFFFF_FFFF, 32'd1, 1'b1);
    get_resp(0);

    // saturation on the 2-bit counter instance
    for (int i = 0; i < 5; i++) begin
      s_req0_valid = 1'b1;
      #1;
      for (int c = 0; c < 20 && !s_req0_ready; c++) tick;
      check("sat_ready", s_req0_ready, 1'b1);
      tick;
      s_req0_valid = 1'b0;
      check("sat_cnt", s_gnt_cnt0, exp_sat[i][1:0]);
      for (int c = 0; c < 10 && !s_resp_valid; c++) tick;
      check("sat_resp", {s_resp_valid, s_resp_result}, {1'b1, 32'd3});
      tick;
    end

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
